// File: rtl/kgp_pkg.sv
// ---------------------------------------------------------------------------
// kgp_pkg
//   Constants shared across the KGPRisc register-file slice.
//   DEF_DW / DEF_AW : default data and address widths (32 x 32 register file)
//   NUM_WR          : number of write ports (ALU writeback + load writeback)
//   W_ALU / W_LOAD  : write-port indices; W_LOAD has priority on collisions
//   REG_ZERO        : index of the optionally hardwired-zero register
// ---------------------------------------------------------------------------
package kgp_pkg;

  localparam int DEF_DW   = 32;
  localparam int DEF_AW   = 5;

  localparam int NUM_WR   = 2;
  localparam int W_ALU    = 0;
  localparam int W_LOAD   = 1;

  localparam int REG_ZERO = 0;

endpackage : kgp_pkg

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if
//   Bus between decode/writeback and the multi-port register file.
//   wr_en     [2]       write enables, bit W_ALU / bit W_LOAD
//   wr_addr   [2*AW]    {W1,W0} write addresses
//   wr_data   [2*DW]    {W1,W0} write data
//   rd_addr   [NR*AW]   read addresses, port k at [k*AW +: AW]
//   rd_data   [NR*DW]   read data,      port k at [k*DW +: DW]
//   rd_busy   [NR]      per-port "register awaits a pending write"
//   busy_set / busy_addr  mark a register as owned by an in-flight producer
//   master : pipeline side (drives writes, read addresses, busy marks)
//   slave  : register file
// ---------------------------------------------------------------------------
interface regfile_mp_if
  import kgp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NR = 2
);

  logic [NUM_WR-1:0]    wr_en;
  logic [NUM_WR*AW-1:0] wr_addr;
  logic [NUM_WR*DW-1:0] wr_data;
  logic [NR*AW-1:0]     rd_addr;
  logic [NR*DW-1:0]     rd_data;
  logic [NR-1:0]        rd_busy;
  logic                 busy_set;
  logic [AW-1:0]        busy_addr;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
    output rd_data, rd_busy
  );

endinterface : regfile_mp_if

// File: rtl/regfile_rd_port.sv
// ---------------------------------------------------------------------------
// regfile_rd_port
//   One combinational read port: storage mux, write->read bypass and
//   bypass-aware busy lookup.
//   rd_addr   in   AW              address read by this port
//   regs      in   DW x 2**AW      current register contents
//   busy      in   2**AW           scoreboard busy bits
//   wr_en     in   NUM_WR          effective write enables (dropped R0 writes
//                                  already masked off by the top)
//   wr_addr   in   AW x NUM_WR     write addresses
//   wr_data   in   DW x NUM_WR     write data
//   rd_data   out  DW              read result (write-first)
//   rd_busy   out  1               busy and not written back this cycle
// ---------------------------------------------------------------------------
module regfile_rd_port
  import kgp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [AW-1:0]     rd_addr,
  input  logic [DW-1:0]     regs    [2**AW],
  input  logic [2**AW-1:0]  busy,
  input  logic [NUM_WR-1:0] wr_en,
  input  logic [AW-1:0]     wr_addr [NUM_WR],
  input  logic [DW-1:0]     wr_data [NUM_WR],
  output logic [DW-1:0]     rd_data,
  output logic              rd_busy
);

  logic [NUM_WR-1:0] hit;
  logic              is_zero;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      hit[j] = wr_en[j] && (wr_addr[j] == rd_addr);
    end

    is_zero = ZERO_REG && (rd_addr == AW'(REG_ZERO));

    // Write-first: a same-cycle write overrides storage; the load port is
    // evaluated last so it wins when both ports target this address.
    rd_data = regs[rd_addr];
    if (hit[W_ALU])  rd_data = wr_data[W_ALU];
    if (hit[W_LOAD]) rd_data = wr_data[W_LOAD];
    if (is_zero)     rd_data = '0;

    // A consumer may proceed in the very cycle its producer writes back.
    rd_busy = busy[rd_addr] && !(|hit) && !is_zero;
  end

endmodule : regfile_rd_port

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Parametrised multi-port register file with a per-register busy
//   scoreboard. Two write ports (ALU = W0, load = W1, load wins on
//   collision), NR combinational read ports with write->read bypass,
//   optional hardwired-zero R0 and synchronous clear.
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears all registers and busy bits,
//               overriding writes and busy_set in the same cycle
//   bus    regfile_mp_if.slave (write ports, read ports, busy mark)
// ---------------------------------------------------------------------------
module regfile_mp
  import kgp_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int NR       = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 2**AW;

  // Unpacked views of the flattened write bus.
  logic [AW-1:0]     wr_addr [NUM_WR];
  logic [DW-1:0]     wr_data [NUM_WR];
  logic [NUM_WR-1:0] wr_en_eff;
  logic              busy_set_eff;

  logic [DW-1:0]     regs_q  [DEPTH];
  logic [DW-1:0]     regs_d  [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [NR*DW-1:0]  rd_data_flat;
  logic [NR-1:0]     rd_busy_flat;

  // A write to the hardwired-zero register is dropped entirely, so it
  // neither updates storage, nor bypasses, nor clears a busy bit.
  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_addr[j]   = bus.wr_addr[j*AW +: AW];
      wr_data[j]   = bus.wr_data[j*DW +: DW];
      wr_en_eff[j] = bus.wr_en[j] && !(ZERO_REG && (wr_addr[j] == AW'(REG_ZERO)));
    end
    busy_set_eff = bus.busy_set && !(ZERO_REG && (bus.busy_addr == AW'(REG_ZERO)));
  end

  // NOTE: combinational next-state logic uses blocking assignments so later
  // statements see earlier ones; the flops below use non-blocking only.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    // Ascending port order makes W_LOAD the last writer on an address clash.
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en_eff[j]) begin
        regs_d[wr_addr[j]] = wr_data[j];
        busy_d[wr_addr[j]] = 1'b0;
      end
    end
    // Set after clear: a newly issued producer owns the register.
    if (busy_set_eff) begin
      busy_d[bus.busy_addr] = 1'b1;
    end
  end

  // NOTE: the storage array is cleared by reset on purpose -- the pipeline
  // relies on every register reading 0 after reset, so this is a flop array,
  // not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    regfile_rd_port #(
      .DW       (DW),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .rd_addr (bus.rd_addr[k*AW +: AW]),
      .regs    (regs_q),
      .busy    (busy_q),
      .wr_en   (wr_en_eff),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_data (rd_data_flat[k*DW +: DW]),
      .rd_busy (rd_busy_flat[k])
    );
  end

  assign bus.rd_data = rd_data_flat;
  assign bus.rd_busy = rd_busy_flat;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Drives two register files in lock-step: A (DW=32, NR=2) and
//   B (DW=16, NR=4), both with a hardwired-zero R0. The driver pushes the
//   expected read result of each port into a scoreboard queue, tagged with
//   the cycle in which it must appear; a monitor pops and compares on the
//   falling edge, away from the active clock edge.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Stimulus shared by both DUTs (B sees the low 16 bits of data).
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        bs;
  logic [4:0]  ba;
  logic [4:0]  ra [4];

  regfile_mp_if #(.DW(32), .AW(5), .NR(2)) ifa ();
  regfile_mp_if #(.DW(16), .AW(5), .NR(4)) ifb ();

  assign ifa.wr_en     = we;
  assign ifa.wr_addr   = {wa[1], wa[0]};
  assign ifa.wr_data   = {wd[1], wd[0]};
  assign ifa.rd_addr   = {ra[1], ra[0]};
  assign ifa.busy_set  = bs;
  assign ifa.busy_addr = ba;

  assign ifb.wr_en     = we;
  assign ifb.wr_addr   = {wa[1], wa[0]};
  assign ifb.wr_data   = {wd[1][15:0], wd[0][15:0]};
  assign ifb.rd_addr   = {ra[3], ra[2], ra[1], ra[0]};
  assign ifb.busy_set  = bs;
  assign ifb.busy_addr = ba;

  regfile_mp #(.DW(32), .AW(5), .NR(2), .ZERO_REG(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  regfile_mp #(.DW(16), .AW(5), .NR(4), .ZERO_REG(1'b1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  typedef struct {
    int          cyc;
    bit          dut_b;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drain_req = 1'b0;
  bit   drain_ack = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares every expectation due in the current cycle.
  initial begin : monitor
    exp_t        e;
    logic [31:0] act_d;
    logic        act_b;
    int          drain_wait;
    drain_wait = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.dut_b) begin
          act_d = {16'h0, ifb.rd_data[e.port*16 +: 16]};
          act_b = ifb.rd_busy[e.port];
        end else begin
          act_d = ifa.rd_data[e.port*32 +: 32];
          act_b = ifa.rd_busy[e.port];
        end
        n_checks++;
        if (e.cyc != cyc || act_d !== e.data || act_b !== e.busy) begin
          n_errors++;
          $display("FAIL %s dut_%s port%0d cyc%0d: got data=%h busy=%b, want data=%h busy=%b (due cyc%0d)",
                   e.name, e.dut_b ? "b" : "a", e.port, cyc, act_d, act_b, e.data, e.busy, e.cyc);
        end
      end
      if (drain_req && !drain_ack) begin
        if (sb.size() == 0) begin
          drain_ack = 1'b1;
        end else if (drain_wait >= 10) begin
          n_checks++;
          n_errors++;
          $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
          sb.delete();
          drain_ack = 1'b1;
        end else begin
          drain_wait++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] e, input int a0, input logic [31:0] d0,
                        input int a1, input logic [31:0] d1, input bit s, input int sa);
    we    = e;
    wa[0] = 5'(a0);
    wd[0] = d0;
    wa[1] = 5'(a1);
    wd[1] = d1;
    bs    = s;
    ba    = 5'(sa);
  endtask

  task automatic idle();
    set_in(2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0);
  endtask

  task automatic set_rd(input int r0, input int r1, input int r2, input int r3);
    ra[0] = 5'(r0);
    ra[1] = 5'(r1);
    ra[2] = 5'(r2);
    ra[3] = 5'(r3);
  endtask

  // Expected value is given at 32 bits; B keeps only the low 16.
  task automatic expect_rd(input int port, input logic [31:0] d, input bit b, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.port = port;
    e.busy = b;
    e.name = name;
    if (port < 2) begin
      e.dut_b = 1'b0;
      e.data  = d;
      sb.push_back(e);
    end
    e.dut_b = 1'b1;
    e.data  = {16'h0, d[15:0]};
    sb.push_back(e);
  endtask

  task automatic expect_all(input logic [31:0] d, input bit b, input string name);
    for (int p = 0; p < 4; p++) expect_rd(p, d, b, name);
  endtask

  task automatic zero_sweep(input string name);
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a, (a + 7) % 32, (a * 3) % 32);
      expect_all(32'h0, 1'b0, name);
      next_cycle();
    end
  endtask

  initial begin : driver
    reset = 1'b1;
    idle();
    set_rd(0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // 1: everything reads zero / not busy after reset
    zero_sweep("reset_sweep");

    // 2: W0 bypass, then persistence
    set_in(2'b01, 5, 32'hDEADBEEF, 0, 32'h0, 1'b0, 0);
    set_rd(5, 5, 5, 3);
    expect_rd(0, 32'hDEADBEEF, 1'b0, "w0_bypass");
    expect_rd(1, 32'hDEADBEEF, 1'b0, "w0_bypass_dup");
    expect_rd(2, 32'hDEADBEEF, 1'b0, "w0_bypass");
    expect_rd(3, 32'h0,        1'b0, "w0_bypass_other");
    next_cycle();
    idle();
    set_rd(5, 6, 5, 5);
    expect_rd(0, 32'hDEADBEEF, 1'b0, "w0_persist");
    expect_rd(1, 32'h0,        1'b0, "w0_neighbour");
    expect_rd(2, 32'hDEADBEEF, 1'b0, "w0_persist");
    expect_rd(3, 32'hDEADBEEF, 1'b0, "w0_persist");
    next_cycle();

    // 3: same-address collision, W1 wins
    set_in(2'b11, 7, 32'h11, 7, 32'h22, 1'b0, 0);
    set_rd(7, 7, 7, 7);
    expect_all(32'h22, 1'b0, "collide_bypass");
    next_cycle();
    idle();
    expect_all(32'h22, 1'b0, "collide_persist");
    next_cycle();

    // Two ports writing different addresses at once
    set_in(2'b11, 8, 32'hAAAA5555, 6, 32'h00006666, 1'b0, 0);
    set_rd(8, 6, 7, 5);
    expect_rd(0, 32'hAAAA5555, 1'b0, "dual_w0");
    expect_rd(1, 32'h00006666, 1'b0, "dual_w1");
    expect_rd(2, 32'h22,       1'b0, "dual_other");
    expect_rd(3, 32'hDEADBEEF, 1'b0, "dual_other");
    next_cycle();
    idle();
    expect_rd(0, 32'hAAAA5555, 1'b0, "dual_persist");
    expect_rd(1, 32'h00006666, 1'b0, "dual_persist");
    next_cycle();

    // 4: hardwired R0 ignores writes and busy_set
    set_in(2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1'b1, 0);
    set_rd(0, 0, 0, 0);
    expect_all(32'h0, 1'b0, "r0_write");
    next_cycle();
    idle();
    expect_all(32'h0, 1'b0, "r0_after");
    next_cycle();

    // 5: scoreboard
    set_in(2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 9);
    set_rd(9, 9, 9, 9);
    expect_all(32'h0, 1'b0, "busy_set_cycle");
    next_cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      expect_all(32'h0, 1'b1, "busy_wait");
      next_cycle();
    end
    set_in(2'b10, 0, 32'h0, 9, 32'h1234, 1'b0, 0);
    expect_all(32'h1234, 1'b0, "busy_writeback");
    next_cycle();
    idle();
    expect_all(32'h1234, 1'b0, "busy_cleared");
    next_cycle();
    set_in(2'b01, 9, 32'h5678, 0, 32'h0, 1'b1, 9);
    expect_all(32'h5678, 1'b0, "set_and_write");
    next_cycle();
    idle();
    expect_all(32'h5678, 1'b1, "set_wins");
    next_cycle();
    set_in(2'b01, 10, 32'hA, 0, 32'h0, 1'b0, 0);
    set_rd(9, 10, 9, 10);
    expect_rd(0, 32'h5678, 1'b1, "busy_other_write");
    expect_rd(1, 32'hA,    1'b0, "busy_other_write");
    expect_rd(2, 32'h5678, 1'b1, "busy_other_write");
    expect_rd(3, 32'hA,    1'b0, "busy_other_write");
    next_cycle();
    set_in(2'b01, 9, 32'h9999, 0, 32'h0, 1'b0, 0);
    set_rd(9, 9, 9, 9);
    expect_all(32'h9999, 1'b0, "w0_clears_busy");
    next_cycle();
    idle();
    expect_all(32'h9999, 1'b0, "w0_cleared");
    next_cycle();

    // 6: reset during activity
    set_in(2'b11, 1, 32'hCAFE00A1, 2, 32'hBEEF00A2, 1'b0, 0);
    next_cycle();
    set_in(2'b01, 3, 32'hF00D00A3, 0, 32'h0, 1'b1, 4);
    next_cycle();
    idle();
    set_rd(1, 2, 3, 4);
    expect_rd(0, 32'hCAFE00A1, 1'b0, "prefill");
    expect_rd(1, 32'hBEEF00A2, 1'b0, "prefill");
    expect_rd(2, 32'hF00D00A3, 1'b0, "prefill");
    expect_rd(3, 32'h0,        1'b1, "prefill_busy");
    next_cycle();
    set_rd(4, 3, 2, 1);
    expect_rd(0, 32'h0,        1'b1, "prefill_busy");
    expect_rd(1, 32'hF00D00A3, 1'b0, "prefill");
    next_cycle();
    reset = 1'b1;
    set_in(2'b01, 1, 32'hFFFF0000, 0, 32'h0, 1'b1, 5);
    next_cycle();
    reset = 1'b0;
    idle();
    set_rd(1, 4, 5, 9);
    expect_all(32'h0, 1'b0, "post_reset");
    next_cycle();
    zero_sweep("post_reset_sweep");

    // Let the monitor consume the remaining expectations.
    drain_req = 1'b1;
    for (int i = 0; i < 50 && !drain_ack; i++) @(posedge clk);
    if (!drain_ack) begin
      $display("FAIL drain_handshake: monitor did not finish, want finish within 50 cycles");
      $fatal(1);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_regfile_mp
